// File: rtl/mem_resp_stage_if.sv
// Handshake and data bundle around the memory-response stage: execute input, writeback output,
// SRAM read response, flush controls and the decode forwarding view.
interface mem_resp_stage_if;
   logic         ms_allowin;
   logic         es_to_ms_valid;
   logic [133:0] es_to_ms_bus;
   logic         es_inflight_on_flush;
   logic         ws_allowin;
   logic         ms_to_ws_valid;
   logic [127:0] ms_to_ws_bus;
   logic         data_sram_data_ok;
   logic [31:0]  data_sram_rdata;
   logic         excp_flush;
   logic         ertn_flush;
   logic         ms_to_ds_valid;
   logic [4:0]   ms_to_ds_dest;
   logic [31:0]  ms_to_ds_result;
   logic         ms_to_ds_ld_wait;
   logic         ms_excp_block;

   modport master (
      output ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
      output ms_to_ds_valid, ms_to_ds_dest, ms_to_ds_result, ms_to_ds_ld_wait, ms_excp_block,
      input  es_to_ms_valid, es_to_ms_bus, es_inflight_on_flush, ws_allowin,
      input  data_sram_data_ok, data_sram_rdata, excp_flush, ertn_flush
   );

   modport slave (
      input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
      input  ms_to_ds_valid, ms_to_ds_dest, ms_to_ds_result, ms_to_ds_ld_wait, ms_excp_block,
      output es_to_ms_valid, es_to_ms_bus, es_inflight_on_flush, ws_allowin,
      output data_sram_data_ok, data_sram_rdata, excp_flush, ertn_flush
   );
endinterface

// File: rtl/mem_resp_stage.sv
// Memory-response stage: holds one instruction from execute, merges its SRAM load data, drives writeback.
// Latency: one cycle execute->register; result reaches writeback combinationally once load data is present.
// Backpressure: ms_allowin drops while a load waits or writeback stalls; an early response parks in a one-entry buffer.
module mem_resp_stage #(
   parameter int CANCEL_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   mem_resp_stage_if.master ms_if
);
   typedef struct packed {
      logic        wait_resp;
      logic [2:0]  ld_type;
      logic [1:0]  addr_lo;
      logic [8:0]  excp_num;
      logic        csr_we;
      logic [13:0] csr_idx;
      logic [31:0] csr_result;
      logic        ertn;
      logic        excp;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] alu_result;
      logic [31:0] pc;
   } ms_bus_t;

   localparam logic [2:0] LD_B  = 3'd1;
   localparam logic [2:0] LD_H  = 3'd2;
   localparam logic [2:0] LD_W  = 3'd3;
   localparam logic [2:0] LD_BU = 3'd4;
   localparam logic [2:0] LD_HU = 3'd5;
   localparam logic [CANCEL_W-1:0] CANCEL_MAX = '1;

   ms_bus_t               ms_bus_r;
   logic                  ms_valid;
   logic                  buf_valid;
   logic [31:0]           rdata_buf;
   logic [CANCEL_W-1:0]   cancel_cnt;

   logic                  flush;
   logic                  resp_mine;
   logic                  ready_go;
   logic                  allowin;
   logic                  ws_valid;
   logic                  ws_fire;
   logic                  buf_cap;
   logic                  ld_wait;
   logic [31:0]           rdata;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [31:0]           ld_res;
   logic [31:0]           result;
   logic [CANCEL_W+1:0]   cancel_sum;
   logic [CANCEL_W+1:0]   inc_ms;
   logic [CANCEL_W+1:0]   inc_es;
   logic [CANCEL_W-1:0]   cancel_nxt;

   assign flush     = ms_if.excp_flush | ms_if.ertn_flush;
   assign resp_mine = ms_if.data_sram_data_ok & (cancel_cnt == '0);
   assign ready_go  = ~ms_bus_r.wait_resp | buf_valid | resp_mine;
   assign allowin   = ~ms_valid | (ready_go & ms_if.ws_allowin);
   assign ws_valid  = ms_valid & ready_go & ~flush;
   assign ws_fire   = ws_valid & ms_if.ws_allowin;
   assign ld_wait   = ms_valid & ms_bus_r.wait_resp & ~buf_valid & ~resp_mine;
   // Park a response only when writeback cannot take the instruction in the same cycle.
   assign buf_cap   = resp_mine & ms_valid & ms_bus_r.wait_resp & ~buf_valid
                    & ~ms_if.ws_allowin & ~flush;
   assign rdata     = buf_valid ? rdata_buf : ms_if.data_sram_rdata;

   always_comb begin
      ld_byte = rdata[7:0];
      case (ms_bus_r.addr_lo)
         2'd1:    ld_byte = rdata[15:8];
         2'd2:    ld_byte = rdata[23:16];
         2'd3:    ld_byte = rdata[31:24];
         default: ld_byte = rdata[7:0];
      endcase
      ld_half = ms_bus_r.addr_lo[1] ? rdata[31:16] : rdata[15:0];

      case (ms_bus_r.ld_type)
         LD_B:    ld_res = {{24{ld_byte[7]}}, ld_byte};
         LD_H:    ld_res = {{16{ld_half[15]}}, ld_half};
         LD_W:    ld_res = rdata;
         LD_BU:   ld_res = {24'd0, ld_byte};
         LD_HU:   ld_res = {16'd0, ld_half};
         default: ld_res = ms_bus_r.alu_result;
      endcase
      result = ms_bus_r.wait_resp ? ld_res : ms_bus_r.alu_result;
   end

   // Responses still owed to flushed loads: the stage's own unanswered load plus any execute has in flight.
   always_comb begin
      inc_ms     = '0;
      inc_es     = '0;
      cancel_sum = {2'b00, cancel_cnt};
      if (flush) begin
         inc_ms[0]  = ms_valid & ms_bus_r.wait_resp & ~buf_valid & ~ms_if.data_sram_data_ok;
         inc_es[0]  = ms_if.es_inflight_on_flush;
         cancel_sum = cancel_sum + inc_ms + inc_es;
      end
      if (ms_if.data_sram_data_ok && (cancel_cnt != '0)) begin
         cancel_sum = cancel_sum - {{(CANCEL_W+1){1'b0}}, 1'b1};
      end
      if (cancel_sum > {2'b00, CANCEL_MAX}) begin
         cancel_nxt = CANCEL_MAX;
      end else begin
         cancel_nxt = cancel_sum[CANCEL_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ms_valid   <= 1'b0;
         ms_bus_r   <= '0;
         buf_valid  <= 1'b0;
         rdata_buf  <= '0;
         cancel_cnt <= '0;
      end else begin
         if (flush) begin
            ms_valid <= 1'b0;
         end else if (ms_if.es_to_ms_valid && allowin) begin
            ms_valid <= 1'b1;
            ms_bus_r <= ms_bus_t'(ms_if.es_to_ms_bus);
         end else if (allowin) begin
            ms_valid <= 1'b0;
         end

         if (flush || ws_fire) begin
            buf_valid <= 1'b0;
         end else if (buf_cap) begin
            buf_valid <= 1'b1;
            rdata_buf <= ms_if.data_sram_rdata;
         end

         cancel_cnt <= cancel_nxt;
      end
   end

   assign ms_if.ms_allowin       = allowin;
   assign ms_if.ms_to_ws_valid   = ws_valid;
   assign ms_if.ms_to_ws_bus     = {ms_bus_r.excp_num, ms_bus_r.csr_we, ms_bus_r.csr_idx,
                                    ms_bus_r.csr_result, ms_bus_r.ertn, ms_bus_r.excp,
                                    ms_bus_r.gr_we, ms_bus_r.dest, result, ms_bus_r.pc};
   assign ms_if.ms_to_ds_valid   = ms_valid & ms_bus_r.gr_we;
   assign ms_if.ms_to_ds_dest    = ms_bus_r.dest;
   assign ms_if.ms_to_ds_result  = result;
   assign ms_if.ms_to_ds_ld_wait = ld_wait;
   assign ms_if.ms_excp_block    = ms_valid & (ms_bus_r.excp | ms_bus_r.ertn);
endmodule

// File: tb/tb_mem_resp_stage.sv
// Bench for mem_resp_stage: vector table, directed multi-cycle sequences, then random traffic against a reference model.
module tb_mem_resp_stage;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_resp_stage_if ms_if();
   mem_resp_stage #(.CANCEL_W(2)) dut (.clk(clk), .reset(reset), .ms_if(ms_if));

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        w;
      logic [2:0]  ld;
      logic [1:0]  a;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vt[12];

   logic [133:0] bus;

   // reference model state
   bit           m_valid;
   logic [133:0] m_bus;
   bit           m_bufv;
   logic [31:0]  m_buf;
   int           drop;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic logic [133:0] mk_bus(input logic w, input logic [2:0] ld, input logic [1:0] a,
                                           input logic [31:0] alu, input logic [31:0] pc);
      return {w, ld, a, 9'h1A5, 1'b1, 14'h0ABC, 32'h5555_AAAA, 1'b0, 1'b0, 1'b1, 5'd7, alu, pc};
   endfunction

   function automatic logic [31:0] load_value(input logic [2:0] ld, input logic [1:0] a,
                                              input logic [31:0] word, input logic [31:0] alu);
      int unsigned b, h;
      b = (word >> (8 * a)) & 32'hFF;
      h = (word >> (16 * a[1])) & 32'hFFFF;
      case (ld)
         3'd1:    return (b >= 128) ? b - 256 : b;
         3'd2:    return (h >= 32768) ? h - 65536 : h;
         3'd3:    return word;
         3'd4:    return b;
         3'd5:    return h;
         default: return alu;
      endcase
   endfunction

   task automatic idle();
      ms_if.es_to_ms_valid       = 1'b0;
      ms_if.es_to_ms_bus         = '0;
      ms_if.es_inflight_on_flush = 1'b0;
      ms_if.ws_allowin           = 1'b1;
      ms_if.data_sram_data_ok    = 1'b0;
      ms_if.data_sram_rdata      = '0;
      ms_if.excp_flush           = 1'b0;
      ms_if.ertn_flush           = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vt[0]  = '{1'b0, 3'd0, 2'd0, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678};
      vt[1]  = '{1'b1, 3'd1, 2'd2, 32'h0000_0000, 32'h0080_0000, 32'hFFFF_FF80};
      vt[2]  = '{1'b1, 3'd1, 2'd0, 32'h0000_0000, 32'h1234_567F, 32'h0000_007F};
      vt[3]  = '{1'b1, 3'd2, 2'd2, 32'h0000_0000, 32'h8001_0000, 32'hFFFF_8001};
      vt[4]  = '{1'b1, 3'd2, 2'd0, 32'h0000_0000, 32'h0000_7FFF, 32'h0000_7FFF};
      vt[5]  = '{1'b1, 3'd3, 2'd1, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vt[6]  = '{1'b1, 3'd4, 2'd3, 32'h0000_0000, 32'hAB00_0000, 32'h0000_00AB};
      vt[7]  = '{1'b1, 3'd5, 2'd2, 32'h0000_0000, 32'h8001_0000, 32'h0000_8001};
      vt[8]  = '{1'b1, 3'd6, 2'd0, 32'hCAFE_F00D, 32'h1111_1111, 32'hCAFE_F00D};
      vt[9]  = '{1'b0, 3'd3, 2'd0, 32'h1111_2222, 32'h0000_0000, 32'h1111_2222};
      vt[10] = '{1'b1, 3'd4, 2'd1, 32'h0000_0000, 32'h0000_FF00, 32'h0000_00FF};
      vt[11] = '{1'b1, 3'd2, 2'd3, 32'h0000_0000, 32'hFFFE_0000, 32'hFFFF_FFFE};

      idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_allowin",  ms_if.ms_allowin, 1);
      chk("rst_ws_valid", ms_if.ms_to_ws_valid, 0);
      chk("rst_ds_valid", ms_if.ms_to_ds_valid, 0);
      chk("rst_ld_wait",  ms_if.ms_to_ds_ld_wait, 0);
      chk("rst_excp_blk", ms_if.ms_excp_block, 0);
      tick();
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         bus = mk_bus(vt[i].w, vt[i].ld, vt[i].a, vt[i].alu, 32'h1C00_0000 + i);
         ms_if.es_to_ms_valid = 1'b1;
         ms_if.es_to_ms_bus   = bus;
         tick();
         ms_if.es_to_ms_valid    = 1'b0;
         ms_if.data_sram_data_ok = vt[i].w;
         ms_if.data_sram_rdata   = vt[i].rdata;
         @(negedge clk);
         chk($sformatf("vec%0d_valid", i), ms_if.ms_to_ws_valid, 1);
         chk($sformatf("vec%0d_bus", i), ms_if.ms_to_ws_bus, {bus[127:64], vt[i].exp, bus[31:0]});
         tick();
         ms_if.data_sram_data_ok = 1'b0;
      end

      // LD_B held for three cycles without a response
      ms_if.es_to_ms_valid = 1'b1;
      ms_if.es_to_ms_bus   = mk_bus(1'b1, 3'd1, 2'd2, 32'h0, 32'h1C00_0100);
      tick();
      ms_if.es_to_ms_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("ldb_wait",     ms_if.ms_to_ds_ld_wait, 1);
         chk("ldb_ws_valid", ms_if.ms_to_ws_valid, 0);
         chk("ldb_allowin",  ms_if.ms_allowin, 0);
         tick();
      end
      ms_if.data_sram_data_ok = 1'b1;
      ms_if.data_sram_rdata   = 32'h0080_0000;
      @(negedge clk);
      chk("ldb_resp_valid", ms_if.ms_to_ws_valid, 1);
      chk("ldb_result",     ms_if.ms_to_ds_result, 32'hFFFF_FF80);
      chk("ldb_wait_off",   ms_if.ms_to_ds_ld_wait, 0);
      tick();
      ms_if.data_sram_data_ok = 1'b0;

      // LD_HU whose response arrives while writeback stalls
      ms_if.ws_allowin     = 1'b0;
      ms_if.es_to_ms_valid = 1'b1;
      ms_if.es_to_ms_bus   = mk_bus(1'b1, 3'd5, 2'd2, 32'h0, 32'h1C00_0200);
      tick();
      ms_if.es_to_ms_valid    = 1'b0;
      ms_if.data_sram_data_ok = 1'b1;
      ms_if.data_sram_rdata   = 32'h8001_0000;
      @(negedge clk);
      chk("buf_resp_valid", ms_if.ms_to_ws_valid, 1);
      chk("buf_allowin",    ms_if.ms_allowin, 0);
      tick();
      ms_if.data_sram_data_ok = 1'b0;
      ms_if.data_sram_rdata   = 32'h1111_2222;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("buf_hold_valid",  ms_if.ms_to_ws_valid, 1);
         chk("buf_hold_wait",   ms_if.ms_to_ds_ld_wait, 0);
         chk("buf_hold_result", ms_if.ms_to_ds_result, 32'h0000_8001);
         tick();
      end
      ms_if.ws_allowin = 1'b1;
      @(negedge clk);
      chk("buf_release_result",  ms_if.ms_to_ds_result, 32'h0000_8001);
      chk("buf_release_allowin", ms_if.ms_allowin, 1);
      tick();
      @(negedge clk);
      chk("buf_gone_valid", ms_if.ms_to_ws_valid, 0);
      tick();

      // flush while waiting plus one more read in flight: two responses must be discarded
      ms_if.es_to_ms_valid = 1'b1;
      ms_if.es_to_ms_bus   = mk_bus(1'b1, 3'd3, 2'd0, 32'h0, 32'h1C00_0300);
      tick();
      ms_if.es_to_ms_valid       = 1'b0;
      ms_if.excp_flush           = 1'b1;
      ms_if.es_inflight_on_flush = 1'b1;
      @(negedge clk);
      chk("fl_ws_valid", ms_if.ms_to_ws_valid, 0);
      chk("fl_ds_valid", ms_if.ms_to_ds_valid, 1);
      chk("fl_ld_wait",  ms_if.ms_to_ds_ld_wait, 1);
      tick();
      ms_if.excp_flush           = 1'b0;
      ms_if.es_inflight_on_flush = 1'b0;
      ms_if.es_to_ms_valid       = 1'b1;
      ms_if.es_to_ms_bus         = mk_bus(1'b1, 3'd3, 2'd0, 32'h0, 32'h1C00_0304);
      ms_if.data_sram_data_ok    = 1'b1;
      ms_if.data_sram_rdata      = 32'hDEAD_0001;
      @(negedge clk);
      chk("fl_after_allowin",  ms_if.ms_allowin, 1);
      chk("fl_after_ds_valid", ms_if.ms_to_ds_valid, 0);
      tick();
      ms_if.es_to_ms_valid  = 1'b0;
      ms_if.data_sram_rdata = 32'hDEAD_0002;
      @(negedge clk);
      chk("fl_drop2_valid", ms_if.ms_to_ws_valid, 0);
      chk("fl_drop2_wait",  ms_if.ms_to_ds_ld_wait, 1);
      tick();
      ms_if.data_sram_rdata = 32'hCAFE_0003;
      @(negedge clk);
      chk("fl_third_valid",  ms_if.ms_to_ws_valid, 1);
      chk("fl_third_result", ms_if.ms_to_ds_result, 32'hCAFE_0003);
      tick();
      ms_if.data_sram_data_ok = 1'b0;

      // flush in the same cycle as the waiting load's response
      ms_if.es_to_ms_valid = 1'b1;
      ms_if.es_to_ms_bus   = mk_bus(1'b1, 3'd4, 2'd0, 32'h0, 32'h1C00_0400);
      tick();
      ms_if.es_to_ms_valid       = 1'b0;
      ms_if.ertn_flush           = 1'b1;
      ms_if.es_inflight_on_flush = 1'b1;
      ms_if.data_sram_data_ok    = 1'b1;
      ms_if.data_sram_rdata      = 32'h0000_00AA;
      @(negedge clk);
      chk("fo_ws_valid", ms_if.ms_to_ws_valid, 0);
      tick();
      ms_if.ertn_flush           = 1'b0;
      ms_if.es_inflight_on_flush = 1'b0;
      ms_if.data_sram_data_ok    = 1'b0;
      @(negedge clk);
      chk("fo_allowin",  ms_if.ms_allowin, 1);
      chk("fo_ds_valid", ms_if.ms_to_ds_valid, 0);
      ms_if.es_to_ms_valid = 1'b1;
      ms_if.es_to_ms_bus   = mk_bus(1'b1, 3'd3, 2'd0, 32'h0, 32'h1C00_0404);
      tick();
      ms_if.es_to_ms_valid    = 1'b0;
      ms_if.data_sram_data_ok = 1'b1;
      ms_if.data_sram_rdata   = 32'h7777_7777;
      @(negedge clk);
      chk("fo_drop_valid", ms_if.ms_to_ws_valid, 0);
      tick();
      ms_if.data_sram_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      chk("fo_own_valid",  ms_if.ms_to_ws_valid, 1);
      chk("fo_own_result", ms_if.ms_to_ds_result, 32'h0BAD_F00D);
      tick();
      ms_if.data_sram_data_ok = 1'b0;

      // asynchronous reset mid-wait with one response owed
      ms_if.excp_flush           = 1'b1;
      ms_if.es_inflight_on_flush = 1'b1;
      tick();
      ms_if.excp_flush           = 1'b0;
      ms_if.es_inflight_on_flush = 1'b0;
      ms_if.es_to_ms_valid       = 1'b1;
      ms_if.es_to_ms_bus         = mk_bus(1'b1, 3'd3, 2'd0, 32'h0, 32'h1C00_0500);
      tick();
      ms_if.es_to_ms_valid = 1'b0;
      @(negedge clk);
      chk("ar_pre_wait", ms_if.ms_to_ds_ld_wait, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_wait",     ms_if.ms_to_ds_ld_wait, 0);
      chk("ar_allowin",  ms_if.ms_allowin, 1);
      chk("ar_ds_valid", ms_if.ms_to_ds_valid, 0);
      tick();
      reset = 1'b0;
      ms_if.es_to_ms_valid = 1'b1;
      ms_if.es_to_ms_bus   = mk_bus(1'b1, 3'd3, 2'd0, 32'h0, 32'h1C00_0504);
      tick();
      ms_if.es_to_ms_valid    = 1'b0;
      ms_if.data_sram_data_ok = 1'b1;
      ms_if.data_sram_rdata   = 32'h1357_9BDF;
      @(negedge clk);
      chk("ar_after_valid",  ms_if.ms_to_ws_valid, 1);
      chk("ar_after_result", ms_if.ms_to_ds_result, 32'h1357_9BDF);
      tick();
      idle();

      // random traffic against the reference model
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      m_valid = 0;
      m_bus   = '0;
      m_bufv  = 0;
      m_buf   = '0;
      drop    = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic [159:0] r;
         bit flush, dok, mine, have, exp_allowin, exp_ws, exp_wait, leave;
         int inc;
         logic [31:0] word, res;

         r = {$urandom, $urandom, $urandom, $urandom, $urandom};
         ms_if.es_to_ms_valid       = ($urandom_range(0, 2) != 0);
         ms_if.es_to_ms_bus         = r[133:0];
         ms_if.ws_allowin           = ($urandom_range(0, 9) < 7);
         ms_if.data_sram_data_ok    = ($urandom_range(0, 9) < 4);
         ms_if.data_sram_rdata      = $urandom;
         ms_if.excp_flush           = ($urandom_range(0, 19) == 0);
         ms_if.ertn_flush           = ($urandom_range(0, 29) == 0);
         ms_if.es_inflight_on_flush = (drop <= 1) && ($urandom_range(0, 1) == 1);
         @(negedge clk);

         flush = ms_if.excp_flush || ms_if.ertn_flush;
         dok   = ms_if.data_sram_data_ok;
         mine  = dok && (drop == 0);
         have  = (m_valid && m_bus[133]) ? (m_bufv || mine) : 1'b1;
         exp_allowin = !m_valid || (have && ms_if.ws_allowin);
         exp_ws      = m_valid && have && !flush;
         exp_wait    = m_valid && m_bus[133] && !m_bufv && !mine;
         word = m_bufv ? m_buf : ms_if.data_sram_rdata;
         res  = m_bus[133] ? load_value(m_bus[132:130], m_bus[129:128], word, m_bus[63:32]) : m_bus[63:32];

         chk("rnd_allowin",   ms_if.ms_allowin, exp_allowin);
         chk("rnd_ws_valid",  ms_if.ms_to_ws_valid, exp_ws);
         chk("rnd_ws_bus",    ms_if.ms_to_ws_bus, {m_bus[127:64], res, m_bus[31:0]});
         chk("rnd_ds_valid",  ms_if.ms_to_ds_valid, m_valid && m_bus[69]);
         chk("rnd_ds_dest",   ms_if.ms_to_ds_dest, m_bus[68:64]);
         chk("rnd_ld_wait",   ms_if.ms_to_ds_ld_wait, exp_wait);
         chk("rnd_excp_blk",  ms_if.ms_excp_block, m_valid && (m_bus[70] || m_bus[71]));
         if (!exp_wait) chk("rnd_ds_result", ms_if.ms_to_ds_result, res);

         leave = exp_ws && ms_if.ws_allowin;
         inc = 0;
         if (flush) inc = int'(m_valid && m_bus[133] && !m_bufv && !dok) + int'(ms_if.es_inflight_on_flush);
         drop = drop + inc - int'(dok && drop > 0);
         if (drop > 3) drop = 3;
         if (flush || leave) m_bufv = 0;
         else if (mine && m_valid && m_bus[133] && !m_bufv && !ms_if.ws_allowin) begin
            m_bufv = 1;
            m_buf  = ms_if.data_sram_rdata;
         end
         if (flush) m_valid = 0;
         else if (ms_if.es_to_ms_valid && exp_allowin) begin
            m_valid = 1;
            m_bus   = ms_if.es_to_ms_bus;
         end else if (exp_allowin) m_valid = 0;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
